// File: rtl/perspective_divide.sv
// Perspective divide: takes a clip-space vertex, fetches 1/w from an external
// reciprocal unit and scales x, y, z through one shared fixed-point multiplier.
module perspective_divide #(
  parameter int FRAC_BITS = 14
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] x_i,
  input  logic [31:0] y_i,
  input  logic [31:0] z_i,
  input  logic [31:0] w_i,
  output logic [31:0] recip_x_o,
  input  logic [31:0] recip_z_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] x_o,
  output logic [31:0] y_o,
  output logic [31:0] z_o,
  output logic [31:0] inv_w_o,
  output logic        clipped_o,
  output logic [2:0]  state_dbg_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECIP = 3'd1,
    MUL_X = 3'd2,
    MUL_Y = 3'd3,
    MUL_Z = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic [31:0] x_q, y_q, z_q, w_q;

  logic signed [31:0] mul_a;
  logic signed [63:0] mul_a_ext, mul_b_ext;
  logic signed [63:0] mul_prod, mul_shifted;
  logic [31:0]        mul_res;
  logic [31:0]        unused_mul_high;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; ready never depends on valid, and a producer holds its payload
  // stable while valid is high and ready is low.
  assign in_ready_o  = (state_q == IDLE) && !reset_i;
  assign out_valid_o = (state_q == DONE);
  assign recip_x_o   = w_q;
  assign state_dbg_o = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid_i) state_d = RECIP;
      RECIP:   state_d = ($signed(w_q) <= 32'sd0) ? DONE : MUL_X;
      MUL_X:   state_d = MUL_Y;
      MUL_Y:   state_d = MUL_Z;
      MUL_Z:   state_d = DONE;
      DONE:    if (out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Shared multiplier: coordinate chosen by state, always scaled by captured 1/w.
  always_comb begin
    mul_a = $signed(x_q);
    case (state_q)
      MUL_Y:   mul_a = $signed(y_q);
      MUL_Z:   mul_a = $signed(z_q);
      default: mul_a = $signed(x_q);
    endcase
  end

  assign mul_a_ext       = {{32{mul_a[31]}}, mul_a};
  assign mul_b_ext       = {{32{inv_w_o[31]}}, inv_w_o};
  assign mul_prod        = mul_a_ext * mul_b_ext;
  assign mul_shifted     = mul_prod >>> FRAC_BITS;
  assign mul_res         = mul_shifted[31:0];
  assign unused_mul_high = mul_shifted[63:32];

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q   <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      w_q       <= '0;
      x_o       <= '0;
      y_o       <= '0;
      z_o       <= '0;
      inv_w_o   <= '0;
      clipped_o <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            x_q <= x_i;
            y_q <= y_i;
            z_q <= z_i;
            w_q <= w_i;
          end
        end
        RECIP: begin
          // Vertices at or behind the eye plane are rejected with zeroed results.
          if ($signed(w_q) <= 32'sd0) begin
            x_o       <= '0;
            y_o       <= '0;
            z_o       <= '0;
            inv_w_o   <= '0;
            clipped_o <= 1'b1;
          end else begin
            inv_w_o   <= recip_z_i;
            clipped_o <= 1'b0;
          end
        end
        MUL_X:   x_o <= mul_res;
        MUL_Y:   y_o <= mul_res;
        MUL_Z:   z_o <= mul_res;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_perspective_divide.sv
// Self-checking bench for perspective_divide: directed vertices, hold/back-pressure,
// mid-vertex reset and randomized vertices against a fixed-point reference model.
module tb_perspective_divide;

  localparam int FRAC = 14;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [31:0] x_i = '0, y_i = '0, z_i = '0, w_i = '0;
  logic [31:0] recip_x_o;
  logic [31:0] recip_z_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [31:0] x_o, y_o, z_o, inv_w_o;
  logic        clipped_o;
  logic [2:0]  state_dbg_o;

  logic [128:0] obs;
  logic [128:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  assign obs = {clipped_o, inv_w_o, z_o, y_o, x_o};

  perspective_divide #(.FRAC_BITS(FRAC)) dut (
    .clk         (clk),
    .reset_i     (reset_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .x_i         (x_i),
    .y_i         (y_i),
    .z_i         (z_i),
    .w_i         (w_i),
    .recip_x_o   (recip_x_o),
    .recip_z_i   (recip_z_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .x_o         (x_o),
    .y_o         (y_o),
    .z_o         (z_o),
    .inv_w_o     (inv_w_o),
    .clipped_o   (clipped_o),
    .state_dbg_o (state_dbg_o)
  );

  always #5 clk = ~clk;

  // Reference: real-valued a*b in 18.14, floored, wrapped to 32 bits.
  function automatic logic [31:0] fx_mul(input logic [31:0] a, input logic [31:0] b);
    int     ia, ib;
    longint sa, sb, p;
    ia = a;
    ib = b;
    sa = ia;
    sb = ib;
    p  = (sa * sb) >>> FRAC;
    return p[31:0];
  endfunction

  function automatic logic [128:0] model(input logic [31:0] x, input logic [31:0] y,
                                         input logic [31:0] z, input logic [31:0] w,
                                         input logic [31:0] r);
    int iw;
    iw = w;
    if (iw <= 0) return {1'b1, 128'd0};
    return {1'b0, r, fx_mul(z, r), fx_mul(y, r), fx_mul(x, r)};
  endfunction

  // Drives one vertex, then scores latency, recip operand, result and hold behaviour.
  task automatic drive_and_score(input logic [31:0] x, input logic [31:0] y,
                                 input logic [31:0] z, input logic [31:0] w,
                                 input logic [31:0] r, input int hold);
    logic [128:0] exp;
    int k;
    int want_lat;
    exp_q.push_back(model(x, y, z, w, r));
    want_lat = exp_q[$][128] ? 2 : 5;
    @(negedge clk);
    x_i = x; y_i = y; z_i = z; w_i = w; recip_z_i = r;
    in_valid_i = 1'b1;
    k = 0;
    while (!in_ready_o && k < 20) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (in_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL accept_wait in_ready_o=%b required 1", in_ready_o);
    end
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    k = 1;
    while (out_valid_o !== 1'b1 && k < 20) begin
      checks++;
      if (recip_x_o !== w) begin
        errors++;
        $display("FAIL recip_x cycle %0d got %h required %h", k, recip_x_o, w);
      end
      @(posedge clk); #1;
      k++;
    end
    checks++;
    if (k != want_lat) begin
      errors++;
      $display("FAIL latency got %0d required %0d", k, want_lat);
    end
    exp = exp_q.pop_front();
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL result got %h required %h", obs, exp);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid_o !== 1'b1 || in_ready_o !== 1'b0 || obs !== exp || recip_x_o !== w) begin
        errors++;
        $display("FAIL hold valid=%b ready=%b got %h required %h", out_valid_o, in_ready_o, obs, exp);
      end
    end
    out_ready_i = 1'b1;
    @(posedge clk); #1;
    out_ready_i = 1'b0;
    checks++;
    if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || obs !== exp) begin
      errors++;
      $display("FAIL release valid=%b ready=%b got %h required %h", out_valid_o, in_ready_o, obs, exp);
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    in_valid_i = 1'b1;
    x_i = 32'h1234_5678; w_i = 32'h0000_4000;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready_o !== 1'b0 || out_valid_o !== 1'b0 || obs !== 129'd0 || recip_x_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_hold ready=%b valid=%b out=%h recip_x=%h required 0,0,0,0",
               in_ready_o, out_valid_o, obs, recip_x_o);
    end
    reset_i = 1'b0;
    in_valid_i = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0 || recip_x_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_release ready=%b valid=%b recip_x=%h required 1,0,0",
               in_ready_o, out_valid_o, recip_x_o);
    end
  endtask

  task automatic test_directed();
    drive_and_score(32'h0000_A000, 32'hFFFF_C000, 32'h0000_2000, 32'h0000_4000, 32'h0000_4000, 0);
    drive_and_score(32'h0000_C000, 32'hFFFF_0000, 32'h0000_4000, 32'h0000_8000, 32'h0000_2000, 2);
    drive_and_score(32'h0000_A000, 32'h0000_B000, 32'h0000_C000, 32'h0000_0000, 32'h0000_4000, 1);
    drive_and_score(32'h0000_A000, 32'h0000_B000, 32'h0000_C000, 32'hFFFF_C000, 32'h0000_4000, 0);
    drive_and_score(32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_8001, 32'h0000_8000, 32'h0000_2000, 0);
    drive_and_score(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h7FFF_0000, 32'h0000_0000, 0);
  endtask

  task automatic test_back_pressure();
    logic [128:0] exp;
    int k;
    drive_and_score(32'h0000_4000, 32'h0000_8000, 32'h0000_C000, 32'h0000_4000, 32'h0000_4000, 0);
    exp_q.push_back(model(32'h0001_4000, 32'hFFFE_0000, 32'h0000_6000, 32'h0000_8000, 32'h0000_2000));
    @(negedge clk);
    x_i = 32'h0001_4000; y_i = 32'hFFFE_0000; z_i = 32'h0000_6000;
    w_i = 32'h0000_8000; recip_z_i = 32'h0000_2000;
    in_valid_i = 1'b1;
    k = 0;
    while (out_valid_o !== 1'b1 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    exp = exp_q.pop_front();
    checks++;
    if (obs !== exp || k != 5) begin
      errors++;
      $display("FAIL bp_first got %h lat %0d required %h lat 5", obs, k, exp);
    end
    exp_q.push_back(model(32'h0000_1000, 32'h0000_2000, 32'h0000_3000, 32'h0000_2000, 32'h0000_8000));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      x_i = 32'h0000_1000; y_i = 32'h0000_2000; z_i = 32'h0000_3000;
      w_i = 32'h0000_2000; recip_z_i = 32'h0000_8000;
      @(posedge clk); #1;
      checks++;
      if (out_valid_o !== 1'b1 || in_ready_o !== 1'b0 || obs !== exp || recip_x_o !== 32'h0000_8000) begin
        errors++;
        $display("FAIL bp_stall valid=%b ready=%b recip_x=%h got %h required %h",
                 out_valid_o, in_ready_o, recip_x_o, obs, exp);
      end
    end
    out_ready_i = 1'b1;
    @(posedge clk); #1;
    out_ready_i = 1'b0;
    checks++;
    if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || obs !== exp) begin
      errors++;
      $display("FAIL bp_release valid=%b ready=%b got %h required %h", out_valid_o, in_ready_o, obs, exp);
    end
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    checks++;
    if (in_ready_o !== 1'b0 || recip_x_o !== 32'h0000_2000) begin
      errors++;
      $display("FAIL bp_accept ready=%b recip_x=%h required 0,00002000", in_ready_o, recip_x_o);
    end
    k = 1;
    while (out_valid_o !== 1'b1 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    exp = exp_q.pop_front();
    checks++;
    if (obs !== exp || k != 5) begin
      errors++;
      $display("FAIL bp_second got %h lat %0d required %h lat 5", obs, k, exp);
    end
    out_ready_i = 1'b1;
    @(posedge clk); #1;
    out_ready_i = 1'b0;
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    x_i = 32'h0003_0000; y_i = 32'h0005_0000; z_i = 32'h0007_0000;
    w_i = 32'h0000_4000; recip_z_i = 32'h0000_4000;
    in_valid_i = 1'b1;
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_i = 1'b1;
    in_valid_i = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid_o !== 1'b0 || in_ready_o !== 1'b0 || obs !== 129'd0 || recip_x_o !== 32'd0) begin
      errors++;
      $display("FAIL mid_reset valid=%b ready=%b out=%h recip_x=%h required 0,0,0,0",
               out_valid_o, in_ready_o, obs, recip_x_o);
    end
    reset_i = 1'b0;
    in_valid_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || obs !== 129'd0) begin
        errors++;
        $display("FAIL aborted_vertex cycle %0d valid=%b ready=%b out=%h required 0,1,0",
                 i, out_valid_o, in_ready_o, obs);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] x, y, z, w, r;
    for (int n = 0; n < 40; n++) begin
      x = $urandom;
      y = $urandom;
      z = $urandom;
      case ($urandom_range(0, 7))
        0:       w = 32'd0;
        1:       w = $urandom | 32'h8000_0000;
        default: w = $urandom_range(1, 32'h7FFF_FFFF);
      endcase
      r = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      drive_and_score(x, y, z, w, r, $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_pressure();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/perspective_divide.md
PERSPECTIVE_DIVIDE -- requirements
Module: perspective_divide

Interface
REQ-001 Parameter: FRAC_BITS, 14, fractional bits of all signed fixed-point operands (18.14).
REQ-002 Port: clk  input  1  sole clock; all state changes on rising edge.
REQ-003 Port: reset_i  input  1  synchronous, active-high reset.
REQ-004 Port: in_valid_i  input  1  input vertex valid.
REQ-005 Port: in_ready_o  output  1  block can accept a vertex.
REQ-006 Port: x_i, y_i, z_i, w_i  input  32 each  signed 18.14 clip-space vertex.
REQ-007 Port: recip_x_o  output  32  operand to the external reciprocal unit (w of current vertex).
REQ-008 Port: recip_z_i  input  32  combinational result 1/recip_x_o from reciprocal unit, 18.14.
REQ-009 Port: out_valid_o  output  1  result valid.
REQ-010 Port: out_ready_i  input  1  downstream accepts result.
REQ-011 Port: x_o, y_o, z_o  output  32 each  signed 18.14 normalized-device coordinates.
REQ-012 Port: inv_w_o  output  32  captured 1/w, 18.14.
REQ-013 Port: clipped_o  output  1  vertex rejected (w <= 0).

Function
REQ-014 States SHALL be IDLE, RECIP, MUL_X, MUL_Y, MUL_Z, DONE.
REQ-015 in_ready_o SHALL be 1 only in IDLE and 0 while reset_i is high; no accept in any other state (one-cycle bubble after DONE handshake).
REQ-016 Accept (in_valid_i & in_ready_o) SHALL register x_i, y_i, z_i, w_i and move IDLE -> RECIP.
REQ-017 recip_x_o SHALL equal registered w in every state (stable for the whole vertex); 0 after reset until first accept.
REQ-018 At end of RECIP: if registered w signed <= 0 -> DONE with x_o=y_o=z_o=inv_w_o=0, clipped_o=1; else capture recip_z_i into inv_w_o, clipped_o=0, -> MUL_X.
REQ-019 MUL_X, MUL_Y, MUL_Z SHALL each take one cycle, writing x_o, y_o, z_o respectively, then -> DONE; one shared multiplier.
REQ-020 Multiply: 64-bit signed product of two 32-bit signed operands, arithmetic shift right by FRAC_BITS (floor toward minus infinity), low 32 bits kept; no rounding, no saturation.
REQ-021 recip_z_i = 0 (w beyond interpolation range) SHALL yield zero coordinates with clipped_o=0.
REQ-022 Latency: accept at edge ending cycle T -> out_valid_o high from cycle T+5 (normal) or T+2 (clipped).
REQ-023 out_valid_o SHALL be 1 exactly in DONE; all result outputs stable while out_valid_o & !out_ready_i.
REQ-024 DONE & out_ready_i -> IDLE next cycle; out_valid_o drops the same edge; result outputs hold last values.
REQ-025 Result outputs SHALL only change in RECIP/MUL_* states or on reset.

Reset
REQ-026 reset_i high at an edge SHALL force IDLE, out_valid_o=0, clipped_o=0, x_o=y_o=z_o=inv_w_o=0, registered inputs and recip_x_o=0, from any state.
REQ-027 Reset mid-vertex SHALL discard that vertex; no out_valid_o pulse for it.
REQ-028 in_valid_i while reset_i high SHALL be ignored.

Verification
REQ-029 w=0x0000_4000, x=0x0000_A000, y=0xFFFF_C000, z=0x0000_2000, stub recip 0x0000_4000 -> x_o/y_o/z_o equal inputs, inv_w_o=0x4000, clipped_o=0, out_valid_o first high at T+5.
REQ-030 w=0x0000_8000, stub recip 0x0000_2000, x=0x0000_C000, y=0xFFFF_0000, z=0x0000_4000 -> x_o=0x0000_6000, y_o=0xFFFF_8000, z_o=0x0000_2000; recip_x_o=0x8000 throughout.
REQ-031 w=0 and w=0xFFFF_C000 -> clipped_o=1, all coordinates and inv_w_o 0, out_valid_o high at T+2.
REQ-032 x=0xFFFF_FFFF, recip 0x0000_2000, w=0x8000 -> x_o=0xFFFF_FFFF (floor shift).
REQ-033 out_ready_i low 10 cycles in DONE with in_valid_i held high -> outputs stable, in_ready_o=0, no accept; ready high -> IDLE next cycle, in_ready_o=1, accept following cycle.
REQ-034 reset_i pulsed while in MUL_Y -> next cycle IDLE, out_valid_o=0, all outputs 0, no result emitted for aborted vertex.
